ball_engine: RTL

Parametrised ball motion engine for the pong core. Integrates a polar velocity (angle `theta`, signed `speed`) into fixed-point screen coordinates on each `tick`, reflects off top/bottom walls, resolves left/right edges as paddle hits, misses or wall bounces, and runs the serve/score sequence. It sits between the game tick divider and the display/scoring logic. It generalises the first-generation ball: parametrised geometry, paddle collision, launch control and external curve control.

---
 rtl/pong_pkg.sv | 12 +
 rtl/ball_engine_if.sv | 29 ++
 rtl/ball_engine_trig_lut.sv | 38 +++
 rtl/ball_engine.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, trig width and angle reflection helpers
package pong_pkg;
    localparam int TRIG_W = 8;
    typedef enum logic [1:0] {IDLE, LOOKUP, STEP, SCORED} state_t;
    // Results are wide; callers truncate to their own angle width, which gives the modulo.
    function automatic logic [15:0] reflect_x(logic [15:0] theta, int tw);
        return (16'd1 << (tw - 1)) - theta;
    endfunction
    function automatic logic [15:0] reflect_y(logic [15:0] theta);
        return 16'd0 - theta;
    endfunction
endpackage

// File: rtl/ball_engine_if.sv
// ball_engine_if: control inputs and ball state outputs of the ball engine
interface ball_engine_if #(
    parameter int THETA_WIDTH = 6,
    parameter int POS_BITS = 4,
    parameter int SPEED_WIDTH = 5
);
    logic tick;
    logic launch;
    logic signed [SPEED_WIDTH-1:0] speed;
    logic [THETA_WIDTH-1:0] launch_theta;
    logic [1:0] curve;
    logic [POS_BITS-1:0] paddle_l;
    logic [POS_BITS-1:0] paddle_r;
    logic [POS_BITS-1:0] x;
    logic [POS_BITS-1:0] y;
    logic [THETA_WIDTH-1:0] theta;
    logic busy;
    logic hit;
    logic score_l;
    logic score_r;
    modport master (
        output tick, launch, speed, launch_theta, curve, paddle_l, paddle_r,
        input  x, y, theta, busy, hit, score_l, score_r
    );
    modport slave (
        input  tick, launch, speed, launch_theta, curve, paddle_l, paddle_r,
        output x, y, theta, busy, hit, score_l, score_r
    );
endinterface

// File: rtl/ball_engine_trig_lut.sv
// trig_lut: registered sin/cos from one shared quarter-wave table
module trig_lut import pong_pkg::*; #(
    parameter int THETA_WIDTH = 6
) (
    input  logic                     clk,
    input  logic [THETA_WIDTH-1:0]   theta,
    output logic signed [TRIG_W-1:0] sin_q,
    output logic signed [TRIG_W-1:0] cos_q
);
    localparam logic [6:0] QUARTER [17] = '{
        7'd0, 7'd12, 7'd25, 7'd37, 7'd49, 7'd60, 7'd71, 7'd81, 7'd90,
        7'd98, 7'd106, 7'd112, 7'd117, 7'd122, 7'd125, 7'd126, 7'd127
    };
    logic [5:0] t6;
    logic signed [TRIG_W-1:0] sin_d;
    logic signed [TRIG_W-1:0] cos_d;
    function automatic logic signed [TRIG_W-1:0] sine(logic [5:0] t);
        logic [4:0] i;
        logic signed [TRIG_W-1:0] m;
        i = t[4] ? 5'd16 - {1'b0, t[3:0]} : {1'b0, t[3:0]};
        m = {1'b0, QUARTER[i]};
        return t[5] ? -m : m;
    endfunction
    // The table has 64 steps per turn; other angle widths are rescaled onto it.
    if (THETA_WIDTH >= 6) begin : g_hi
        assign t6 = theta[THETA_WIDTH-1 -: 6];
    end else begin : g_lo
        assign t6 = {theta, {(6-THETA_WIDTH){1'b0}}};
    end
    always_comb begin
        sin_d = sine(t6);
        cos_d = sine(t6 + 6'd16);
    end
    always_ff @(posedge clk) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
    end
endmodule

// File: rtl/ball_engine.sv
// ball_engine: polar-velocity ball integrator with wall/paddle reflection and serve/score sequencing
module ball_engine import pong_pkg::*; #(
    parameter int THETA_WIDTH = 6,
    parameter int POS_BITS = 4,
    parameter int FRAC_BITS = 17,
    parameter int SPEED_WIDTH = 5,
    parameter int PADDLE_H = 3,
    parameter int WALLS = 0,
    parameter int SCORE_HOLD = 8
) (
    input logic clk,
    input logic reset,
    ball_engine_if.slave bus
);
    localparam int ACC = POS_BITS + FRAC_BITS;
    localparam int AW = ACC + 1;
    localparam int PW = TRIG_W + SPEED_WIDTH;
    localparam int CW = $clog2(SCORE_HOLD + 1);
    localparam logic [ACC-1:0] CENTRE = ACC'(1) << (ACC - 1);
    state_t st_q, st_d;
    logic launched_q, launched_d;
    logic [ACC-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [THETA_WIDTH-1:0] th_q, th_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic hit_q, hit_d, sl_q, sl_d, sr_q, sr_d;
    logic signed [TRIG_W-1:0] sin_v, cos_v;
    logic signed [PW-1:0] dx, dy;
    logic [ACC:0] nx, ny;
    logic edge_x, edge_y, right, pad_ok, miss;
    logic [POS_BITS-1:0] yi, pad;
    trig_lut #(.THETA_WIDTH(THETA_WIDTH)) u_lut (
        .clk(clk), .theta(th_q), .sin_q(sin_v), .cos_q(cos_v)
    );
    assign dx = PW'(cos_v) * PW'(bus.speed);
    assign dy = PW'(sin_v) * PW'(bus.speed);
    // Bit ACC flags both running past the top (d>0) and going negative (d<0).
    assign nx = {1'b0, ax_q} + AW'(dx);
    assign ny = {1'b0, ay_q} + AW'(dy);
    assign edge_x = nx[ACC];
    assign edge_y = ny[ACC];
    assign right = ~dx[PW-1];
    assign yi = ay_q[ACC-1 -: POS_BITS];
    assign pad = right ? bus.paddle_r : bus.paddle_l;
    assign pad_ok = WALLS != 0 || (int'(yi) >= int'(pad) && int'(yi) <= int'(pad) + PADDLE_H - 1);
    assign miss = edge_x && !pad_ok;
    always_comb begin
        st_d = st_q;
        launched_d = launched_q;
        ax_d = ax_q;
        ay_d = ay_q;
        th_d = th_q;
        cnt_d = cnt_q;
        hit_d = 1'b0;
        sl_d = 1'b0;
        sr_d = 1'b0;
        case (st_q)
            IDLE: begin
                if (bus.launch) begin
                    th_d = bus.launch_theta;
                    launched_d = 1'b1;
                end else if (bus.tick && launched_q) begin
                    st_d = LOOKUP;
                end
            end
            LOOKUP: st_d = STEP;
            STEP: begin
                st_d = miss ? SCORED : IDLE;
                sl_d = miss && right;
                sr_d = miss && !right;
                if (!miss) begin
                    ax_d = edge_x ? ax_q : nx[ACC-1:0];
                    ay_d = edge_y ? ay_q : ny[ACC-1:0];
                    hit_d = edge_x;
                    th_d = edge_x && edge_y ? THETA_WIDTH'(reflect_x(reflect_y(16'(th_q)), THETA_WIDTH))
                         : edge_x ? THETA_WIDTH'(reflect_x(16'(th_q), THETA_WIDTH))
                         : edge_y ? THETA_WIDTH'(reflect_y(16'(th_q)))
                         : bus.curve == 2'b01 ? th_q + THETA_WIDTH'(1)
                         : bus.curve == 2'b11 ? th_q - THETA_WIDTH'(1) : th_q;
                end
            end
            SCORED: begin
                if (bus.tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(SCORE_HOLD - 1)) begin
                        cnt_d = '0;
                        st_d = IDLE;
                        launched_d = 1'b0;
                        ax_d = CENTRE;
                        ay_d = CENTRE;
                        th_d = '0;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= IDLE;
            launched_q <= 1'b0;
            ax_q <= CENTRE;
            ay_q <= CENTRE;
            th_q <= '0;
            cnt_q <= '0;
            hit_q <= 1'b0;
            sl_q <= 1'b0;
            sr_q <= 1'b0;
        end else begin
            st_q <= st_d;
            launched_q <= launched_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
            th_q <= th_d;
            cnt_q <= cnt_d;
            hit_q <= hit_d;
            sl_q <= sl_d;
            sr_q <= sr_d;
        end
    end
    assign bus.x = ax_q[ACC-1 -: POS_BITS];
    assign bus.y = yi;
    assign bus.theta = th_q;
    assign bus.busy = st_q != IDLE;
    assign bus.hit = hit_q;
    assign bus.score_l = sl_q;
    assign bus.score_r = sr_q;
endmodule
